// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode/state enums and flag struct for the ALU sequencer
package alu_pkg;
    localparam int WIDTH  = 15;
    localparam int ADDR_W = 3;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_SHL, OP_PASSB
    } op_e;
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_e;
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 15-bit ALU producing result and {carry, overflow, zero}
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output flags_t           f
);
    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    always_comb begin
        sub   = op == OP_SUB;
        arith = op == OP_ADD || sub;
        bx    = sub ? ~b : b;
        // SUB shares the adder as A + ~B + 1
        sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        case (op)
            OP_ADD, OP_SUB: y = sum[WIDTH-1:0];
            OP_AND:         y = a & b;
            OP_OR:          y = a | b;
            OP_XOR:         y = a ^ b;
            OP_NOTA:        y = ~a;
            OP_SHL:         y = {a[WIDTH-2:0], 1'b0};
            default:        y = b;
        endcase
        f.carry    = arith ? sum[WIDTH] : (op == OP_SHL) ? a[WIDTH-1] : 1'b0;
        f.overflow = arith && (a[WIDTH-1] == bx[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
        f.zero     = y == '0;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: reads two operands from memory, executes one ALU op and writes the result back
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_srcA,
    input  logic [ADDR_W-1:0] cmd_srcB,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              ren,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [WIDTH-1:0]  dataOut,
    output logic              wen,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [WIDTH-1:0]  dataIn,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [2:0]        flags
);
    state_e            state, next;
    op_e               op_q;
    logic [ADDR_W-1:0] src_a, src_b, dst;
    logic [WIDTH-1:0]  a_q, alu_y;
    flags_t            alu_f, flags_q;

    // B is consumed straight from the memory's registered read port during EXEC
    alu_core u_alu (.a(a_q), .b(dataOut), .op(op_q), .y(alu_y), .f(alu_f));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_ADD;
            src_a   <= '0;
            src_b   <= '0;
            dst     <= '0;
            a_q     <= '0;
            result  <= '0;
            flags_q <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q  <= op_e'(cmd_op);
                src_a <= cmd_srcA;
                src_b <= cmd_srcB;
                dst   <= cmd_dst;
            end
            if (state == RD_B) a_q <= dataOut;
            if (state == EXEC) begin
                result  <= alu_y;
                flags_q <= alu_f;
            end
        end
    end

    always_comb begin
        next      = state == IDLE ? (cmd_valid ? RD_A : IDLE) :
                    state == RD_A ? RD_B :
                    state == RD_B ? EXEC :
                    state == EXEC ? WB : IDLE;
        cmd_ready = state == IDLE;
        ren       = state == RD_A || state == RD_B;
        rdAddr    = state == RD_A ? src_a : state == RD_B ? src_b : '0;
        wen       = state == WB;
        wrAddr    = state == WB ? dst : '0;
        dataIn    = state == WB ? result : '0;
        done      = state == WB;
    end

    assign flags = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a registered 8x15 memory model
module tb_alu_sequencer;
    import alu_pkg::*;

    logic              clock = 0, reset_n = 0, cmd_valid = 0;
    logic              cmd_ready, ren, wen, done;
    logic [2:0]        cmd_op = 0, flags;
    logic [ADDR_W-1:0] cmd_srcA = 0, cmd_srcB = 0, cmd_dst = 0, rdAddr, wrAddr;
    logic [WIDTH-1:0]  dataOut = 0, dataIn, result;
    logic [WIDTH-1:0]  mem [8];

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB), .cmd_dst(cmd_dst),
        .ren(ren), .rdAddr(rdAddr), .dataOut(dataOut), .wen(wen), .wrAddr(wrAddr),
        .dataIn(dataIn), .done(done), .result(result), .flags(flags)
    );

    always @(posedge clock) begin
        if (ren) dataOut <= mem[rdAddr];
        if (wen) mem[wrAddr] = dataIn;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [WIDTH-1:0]  y;
        logic [2:0]        f;
        logic [ADDR_W-1:0] d;
        int                acc;
    } exp_t;
    exp_t              sb [$];
    exp_t              e;
    logic [ADDR_W-1:0] rd_exp [$];
    int                last_acc = -100;

    // independent reference: integer arithmetic with signed range test for overflow
    function automatic logic [17:0] model(input logic [2:0] op, input logic [14:0] a, input logic [14:0] b);
        int ua, ub, sa, sbv, t, s;
        logic [14:0] y;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = a[14] ? ua - 32768 : ua;
        sbv = b[14] ? ub - 32768 : ub;
        c = 0; v = 0; t = 0; s = 0;
        case (op)
            3'd0: begin t = ua + ub; y = t[14:0]; c = t > 32767; s = sa + sbv; v = s > 16383 || s < -16384; end
            3'd1: begin t = ua + (32767 - ub) + 1; y = t[14:0]; c = t > 32767; s = sa - sbv; v = s > 16383 || s < -16384; end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: begin y = {a[13:0], 1'b0}; c = a[14]; end
            default: y = b;
        endcase
        return {y, c, v, y == 15'd0};
    endfunction

    always @(negedge clock) begin
        check("ren_wen_exclusive", ren & wen, 0);
        check("cmd_ready", cmd_ready, !(cyc >= last_acc && cyc <= last_acc + 3));
        check("wen_vs_done", wen, done);
        if (ren) begin
            if (rd_exp.size() == 0) check("unexpected_ren", 1, 0);
            else check("rdAddr", rdAddr, rd_exp.pop_front());
        end
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("result", result, e.y);
                check("flags", flags, e.f);
                check("dataIn", dataIn, e.y);
                check("wrAddr", wrAddr, e.d);
                check("latency", cyc - e.acc, 3);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input bit keep, input bit push);
        int n = 0;
        logic [17:0] m;
        @(negedge clock);
        cmd_op = op; cmd_srcA = a; cmd_srcB = b; cmd_dst = d; cmd_valid = 1;
        while (!cmd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        @(posedge clock);
        #1;
        last_acc = cyc;
        rd_exp.push_back(a);
        rd_exp.push_back(b);
        if (push) begin
            m = model(op, mem[a], mem[b]);
            sb.push_back('{m[17:3], m[2:0], d, cyc});
        end
        if (!keep) cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rd_exp.size() != 0) && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", sb.size() + rd_exp.size(), 0);
        @(posedge clock);
        #1;
    endtask

    int a1;
    logic [17:0] m6;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 15'(i);
        repeat (3) @(negedge clock);
        check("reset_outputs", {ren, wen, done, rdAddr, wrAddr, dataIn, result, flags}, 0);
        reset_n = 1;
        #1 check("ready_after_reset", cmd_ready, 1);

        send(3'd0, 3, 5, 0, 0, 1); drain();
        check("mem0_add", mem[0], 15'd8);
        send(3'd1, 2, 5, 1, 0, 1); drain();
        check("mem1_sub", mem[1], 15'h7FFD);
        send(3'd4, 4, 4, 7, 0, 1); drain();
        check("mem7_xor", mem[7], 15'd0);

        @(negedge clock);
        mem[2] = 15'h3FFF;
        mem[3] = 15'd1;
        send(3'd0, 2, 3, 2, 0, 1); drain();
        check("mem2_ovf", mem[2], 15'h4000);
        send(3'd7, 0, 2, 5, 0, 1); drain();
        check("mem5_passb", mem[5], 15'h4000);

        send(3'd5, 1, 1, 3, 1, 1);
        a1 = last_acc;
        send(3'd6, 1, 0, 4, 0, 1);
        check("b2b_gap", last_acc - a1, 5);
        drain();

        for (int i = 0; i < 10; i++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 5)), 0, 1);
            drain();
        end

        send(3'd0, 1, 2, 6, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 0;
        last_acc = -100;
        #1 check("midop_reset_outputs", {ren, wen, done, rdAddr, wrAddr, dataIn, result, flags}, 0);
        repeat (3) @(negedge clock);
        check("mem6_untouched", mem[6], 15'd6);
        reset_n = 1;
        #1 check("ready_after_midop_reset", cmd_ready, 1);

        m6 = model(3'd0, mem[1], mem[2]);
        send(3'd0, 1, 2, 6, 0, 1); drain();
        check("mem6_after_reset", mem[6], m6[17:3]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execution stage sitting directly upstream of the 8x15 register memory, driving its ren/wen/rdAddr/wrAddr/dataIn and consuming its registered dataOut.
- Accepts one three-address command (op, srcA, srcB, dst) over a valid/ready handshake.
- Reads both operands from memory, computes a 15-bit ALU result with flags, and writes the result back to memory at dst.
- Reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 15, data/operand width; matches memory word.
ADDR_W, 3, memory address width (8 entries).

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command (high only in IDLE).
cmd_op  input  3  opcode (alu_pkg::op_e).
cmd_srcA  input  ADDR_W  operand A address.
cmd_srcB  input  ADDR_W  operand B address.
cmd_dst  input  ADDR_W  result address.
ren  output  1  memory read enable.
rdAddr  output  ADDR_W  memory read address.
dataOut  input  WIDTH  memory read data (valid the cycle after ren).
wen  output  1  memory write enable.
wrAddr  output  ADDR_W  memory write address.
dataIn  output  WIDTH  memory write data.
done  output  1  one-cycle pulse, result written this cycle.
result  output  WIDTH  last result; held until next WB.
flags  output  3  {carry, overflow, zero} of last result; held until next WB.

Behaviour:
- Reset (reset_n low, async): state=IDLE; ren=0, wen=0, done=0; rdAddr, wrAddr, dataIn, result and flags all 0; cmd_ready=1 once reset deasserts.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. op/srcA/srcB/dst are latched at that edge. Command inputs are ignored outside IDLE.
- FSM sequence: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE. Each state lasts exactly one cycle except IDLE.
  - RD_A: ren=1, rdAddr=srcA.
  - RD_B: ren=1, rdAddr=srcB; A captured from dataOut at the end of this cycle.
  - EXEC: ren=0; B is taken from dataOut; ALU result and flags are registered at the end of this cycle.
  - WB: wen=1, wrAddr=dst, dataIn=result register, done=1.
- Latency: done is high in the 4th cycle after the accepting edge. Throughput is one command per 5 cycles; cmd_ready rises in the cycle after WB.
- ren and wen are never both high in the same cycle.
- Ops (all arithmetic modulo 2^WIDTH):
  - ADD=0: A+B.
  - SUB=1: A+~B+1.
  - AND=2, OR=3, XOR=4.
  - NOTA=5: ~A.
  - SHL=6: A<<1, carry=A[14].
  - PASSB=7: B.
- Flags:
  - carry: carry-out bit 15 for ADD/SUB (SUB carry=1 means no borrow); the shifted-out bit for SHL; 0 otherwise.
  - overflow: two's-complement signed overflow for ADD/SUB; 0 otherwise.
  - zero: result==0.
- Boundaries:
  - srcA==srcB is legal (same value read twice).
  - dst may equal srcA/srcB; the write lands at WB, after both reads.
  - Back-to-back commands: the next command's RD_A follows at least one IDLE cycle after WB, so no read-during-write hazard.
- Reset mid-operation: the command is abandoned, no wen is issued, done is not pulsed, and result/flags are cleared.

Decomposition:
- Package alu_pkg:
  - WIDTH and ADDR_W constants.
  - op_e enum (3-bit).
  - state_e enum (IDLE, RD_A, RD_B, EXEC, WB).
  - flags_t packed struct {carry, overflow, zero}.
- Sub-module alu_core: purely combinational (a, b, op -> y, flags_t), instantiated in EXEC. alu_sequencer holds the FSM, operand registers and the memory interface.

Test Plan:
- Memory preloaded with memory[i]=i.
  - ADD srcA=3, srcB=5, dst=0 -> done at cycle 4 after accept, result=8, flags=000, memory[0]=8.
  - SUB srcA=2, srcB=5, dst=1 -> result=15'h7FFD, carry=0, overflow=0, zero=0, memory[1]=15'h7FFD.
- XOR srcA=4, srcB=4, dst=7 -> result=0, zero=1; two ren cycles both with rdAddr=4; memory[7]=0.
- Preload memory[2]=15'h3FFF, memory[3]=1; ADD srcA=2, srcB=3, dst=2 -> result=15'h4000, overflow=1, carry=0; a following PASSB srcA=0, srcB=2 reads back 15'h4000.
- cmd_valid held high with two commands -> second accepted exactly 5 cycles after first; cmd_ready low during RD_A..WB; ren/wen never coincide.
- reset_n pulled low during EXEC of ADD dst=6 -> wen stays 0, done never pulses, memory[6] unchanged (6), all outputs 0; after release, cmd_ready=1 and the next command completes normally.
